// File: rtl/ring_checker.sv
// Ring-counter sequence checker: tracks a rotating one-hot pattern,
// locks after a run of correct steps and counts sequence errors.
module ring_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         Q_in,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     locked,
  output logic                     err,
  output logic                     wrap,
  output logic [7:0]               err_count
);

  localparam int PW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] exp_nx;
  logic [3:0]       cnt;
  logic [3:0]       cnt_nx;
  logic [3:0]       cnt_inc;
  logic [PW-1:0]    pos_nx;
  logic             err_nx;
  logic             wrap_nx;
  logic [7:0]       ecnt_nx;

  logic             one_hot;
  logic             hit;
  logic [WIDTH-1:0] rot;
  logic [PW-1:0]    enc;

  assign one_hot = (Q_in != '0) &&
                   ((Q_in & (Q_in - 1'b1)) == '0);
  assign hit     = (Q_in == expected);
  assign rot     = {Q_in[WIDTH-2:0], Q_in[WIDTH-1]};
  assign cnt_inc = cnt + 4'd1;
  assign locked  = (state == LOCKED);

  always_comb begin
    enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (Q_in[i]) enc = PW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      expected  <= '0;
      cnt       <= '0;
      pos       <= '0;
      err       <= 1'b0;
      wrap      <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nx;
      expected  <= exp_nx;
      cnt       <= cnt_nx;
      pos       <= pos_nx;
      err       <= err_nx;
      wrap      <= wrap_nx;
      err_count <= ecnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    exp_nx   = expected;
    cnt_nx   = cnt;
    pos_nx   = pos;
    err_nx   = 1'b0;
    wrap_nx  = 1'b0;
    ecnt_nx  = err_count;
    if (in_valid) begin
      if (one_hot) pos_nx = enc;
      unique case (state)
        SEARCH: begin
          if (one_hot) begin
            exp_nx   = rot;
            cnt_nx   = '0;
            state_nx = TRACK;
          end
        end
        TRACK: begin
          // expected is always one-hot here, so hit implies one_hot
          if (hit) begin
            exp_nx = rot;
            cnt_nx = cnt_inc;
            if (cnt_inc == 4'(LOCK_CNT)) state_nx = LOCKED;
          end else if (one_hot) begin
            exp_nx = rot;
            cnt_nx = '0;
          end else begin
            state_nx = SEARCH;
          end
        end
        LOCKED: begin
          if (hit) begin
            exp_nx  = rot;
            wrap_nx = Q_in[0];
          end else begin
            err_nx   = 1'b1;
            state_nx = SEARCH;
            if (err_count != 8'hFF) ecnt_nx = err_count + 8'd1;
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

endmodule
